// File: rtl/vec_result_tx.sv
// vec_result_tx: captures a packed multiplier result and serialises it LSB-first as UART bytes.
// Optional trailing XOR checksum byte when VEC_RESULT_TX_CHECKSUM_EN is defined.
module vec_result_tx #(
  parameter int N     = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*WIDTH*N-1:0]   result,
  input  logic                   result_valid,
  output logic                   result_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done
);
  localparam int RW     = 2*WIDTH*N;
  localparam int NBYTES = (RW + 7) / 8;
  localparam int PW     = NBYTES*8;
  localparam int CW     = $clog2(NBYTES + 1);
`ifdef VEC_RESULT_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif
  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] shadow, sel;
  logic          done_q, done_nxt, xfer, last;
  assign sel          = shadow >> {cnt, 3'b000};
  assign result_ready = state == IDLE;
  assign tx_valid     = state != IDLE;
  assign busy         = state != IDLE;
  assign done         = done_q;
`ifdef VEC_RESULT_TX_CHECKSUM_EN
  assign tx_data = state == SEND ? sel[7:0] : state == CSUM ? csum : 8'h00;
`else
  assign tx_data = state == SEND ? sel[7:0] : 8'h00;
`endif
  always_comb begin
    xfer = tx_valid & tx_ready;
    last = cnt == CW'(NBYTES - 1);
`ifdef VEC_RESULT_TX_CHECKSUM_EN
    nxt = state == IDLE ? (result_valid ? SEND : IDLE)
        : state == SEND ? (xfer && last ? CSUM : SEND)
        : (xfer ? IDLE : CSUM);
    done_nxt = state == CSUM && xfer;
`else
    nxt = state == IDLE ? (result_valid ? SEND : IDLE) : (xfer && last ? IDLE : SEND);
    done_nxt = state == SEND && xfer && last;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      done_q <= 1'b0;
`ifdef VEC_RESULT_TX_CHECKSUM_EN
      csum   <= 8'h00;
`endif
    end else begin
      state  <= nxt;
      done_q <= done_nxt;
      if (state == IDLE && result_valid) begin
        shadow <= PW'(result);
        cnt    <= '0;
`ifdef VEC_RESULT_TX_CHECKSUM_EN
        csum   <= 8'h00;
`endif
      end else if (state == SEND && xfer) begin
        cnt  <= last ? cnt : cnt + CW'(1);
`ifdef VEC_RESULT_TX_CHECKSUM_EN
        csum <= csum ^ tx_data;
`endif
      end
    end
  end
endmodule

// File: tb/tb_vec_result_tx.sv
// tb_vec_result_tx: scoreboard bench for vec_result_tx (N=2/WIDTH=8 and a padded N=1/WIDTH=6 instance).
module tb_vec_result_tx;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] result = '0;
  logic        result_valid = 1'b0, tx_ready = 1'b0;
  logic        result_ready, tx_valid, busy, done;
  logic [7:0]  tx_data;
  logic [11:0] r1 = '0;
  logic        rv1 = 1'b0, ty1 = 1'b0, rr1, tv1, busy1, done1;
  logic [7:0]  td1;
  int          total = 0, bad = 0;
  logic [7:0]  q[$];
  logic        exp_done = 1'b0, stalled = 1'b0;
  logic [7:0]  held = '0;
  always #5 clk = ~clk;
  vec_result_tx #(.N(2), .WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );
  vec_result_tx #(.N(1), .WIDTH(6)) u1 (
    .clk(clk), .rst_n(rst_n), .result(r1), .result_valid(rv1),
    .result_ready(rr1), .tx_data(td1), .tx_valid(tv1),
    .tx_ready(ty1), .busy(busy1), .done(done1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic push(input logic [31:0] v);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      q.push_back(v[8*i +: 8]);
      x ^= v[8*i +: 8];
    end
`ifdef VEC_RESULT_TX_CHECKSUM_EN
    q.push_back(x);
`endif
  endtask
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd);
    logic nd = 1'b0;
    @(negedge clk);
    tx_ready = rdy;
    result_valid = rv;
    result = rd;
    chk("done", done, exp_done);
    chk("result_ready", result_ready, q.size() == 0);
    chk("tx_valid", tx_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    if (stalled) chk("stable", tx_data, held);
    stalled = tx_valid && !rdy;
    held = tx_data;
    if (rv && result_ready) push(rd);
    else if (tx_valid && rdy && q.size() != 0) begin
      chk("byte", tx_data, q[0]);
      void'(q.pop_front());
      nd = q.size() == 0;
    end
    @(posedge clk);
    exp_done = nd;
  endtask
  task automatic drain(input bit bp);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      cyc(bp ? (n >= 2 && n % 2 == 0) : 1'b1, 1'b0, 32'h0);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask
  task automatic reset_values();
    chk("rst_result_ready", result_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask
  initial begin
    #12 reset_values();
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'hA1B2C3D4);
    drain(1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'hA1B2C3D4);
    drain(1'b1);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'hCAFE0001);
    while (q.size() != 0) cyc(1'b1, 1'b1, 32'h11223344);
    cyc(1'b1, 1'b1, 32'h55667788);
    drain(1'b0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0BADF00D);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 reset_values();
    q.delete();
    exp_done = 1'b0;
    stalled = 1'b0;
    @(posedge clk);
    #1 reset_values();
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rv1 = 1'b1; r1 = 12'hABC; ty1 = 1'b1;
    chk("pad_ready", rr1, 1);
    @(negedge clk);
    rv1 = 1'b0;
    chk("pad_ready_low", rr1, 0);
    chk("pad_valid", tv1, 1);
    chk("pad_b0", td1, 8'hBC);
    @(negedge clk);
    chk("pad_b1", td1, 8'h0A);
    chk("pad_done_early", done1, 0);
`ifdef VEC_RESULT_TX_CHECKSUM_EN
    @(negedge clk);
    chk("pad_csum", td1, 8'hB6);
`endif
    @(negedge clk);
    chk("pad_done", done1, 1);
    chk("pad_ready_end", rr1, 1);
    chk("pad_valid_end", tv1, 0);
    @(negedge clk);
    chk("pad_done_once", done1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
